// File: rtl/mem_responder.sv
// mem_responder
//   Fully pipelined word memory acting as responder to a CPU memory initiator.
//   One request is accepted on every rising edge with enable high; there is no
//   stall path. A write updates storage at the accepting edge. A read samples
//   storage at the accepting edge and its data leaves a LATENCY-stage
//   {valid, data} shift register LATENCY cycles later.
//
// Parameters
//   LATENCY    cycles from read accept to data_valid (1..8)
//   DEPTH      number of 16-bit words stored (power of two, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset; clears pipeline and outputs only
//   addr       byte address; word index = addr[15:1] modulo DEPTH
//   enable     request strobe
//   wr         1 = write, 0 = read (qualified by enable)
//   data_in    write data
//   data_out   read data; 16'h0000 whenever data_valid is low
//   data_valid one-cycle pulse per completed read
module mem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]   r_mem [DEPTH];
  logic [14:0]   w_word;
  logic [AW-1:0] w_idx;
  logic          w_wr;
  logic          w_rd;

  logic [LATENCY-1:0] r_vld;
  logic [15:0]        r_dat [LATENCY];

  // Upper word-address bits are dropped so the index wraps modulo DEPTH.
  assign w_word = addr[15:1];
  assign w_idx  = w_word[AW-1:0];

  // Storage carries no reset, so a write strobe must be masked while reset
  // is held; the pipeline side is masked by its own reset branch.
  assign w_wr = enable & wr & rst_n;
  assign w_rd = enable & ~wr;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[w_idx] <= data_in;
    end
  end

  // Stage 0: the read snapshots storage here, so a later write to the same
  // word cannot alter data already in flight. Non-read cycles load zero data
  // so the output stage reads 0 whenever it is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld[0] <= 1'b0;
      r_dat[0] <= '0;
    end else begin
      r_vld[0] <= w_rd;
      r_dat[0] <= w_rd ? r_mem[w_idx] : '0;
    end
  end

  for (genvar g = 1; g < LATENCY; g++) begin : g_stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld[g] <= 1'b0;
        r_dat[g] <= '0;
      end else begin
        r_vld[g] <= r_vld[g-1];
        r_dat[g] <= r_dat[g-1];
      end
    end
  end

  assign data_valid = r_vld[LATENCY-1];
  assign data_out   = r_dat[LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
//   Drives one shared request stream into three mem_responder instances
//   (LATENCY 1, 4 and 8) and compares each output every cycle against a
//   reference model: a word array plus, per latency, a table of the
//   {valid, data} value due at each sampling edge.
module tb_mem_responder;

  localparam int MAXC = 4096;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] data_in = '0;

  logic [15:0] do_1, do_4, do_8;
  logic        dv_1, dv_4, dv_8;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [15:0] mem_m [32768];
  logic [16:0] exp_t [3][MAXC];
  int          lat   [3] = '{1, 4, 8};

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(1), .DEPTH(32768)) u_l1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .enable(enable), .wr(wr),
    .data_in(data_in), .data_out(do_1), .data_valid(dv_1));

  mem_responder #(.LATENCY(4), .DEPTH(32768)) u_l4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .enable(enable), .wr(wr),
    .data_in(data_in), .data_out(do_4), .data_valid(dv_4));

  mem_responder #(.LATENCY(8), .DEPTH(32768)) u_l8 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .enable(enable), .wr(wr),
    .data_in(data_in), .data_out(do_8), .data_valid(dv_8));

  function automatic logic [16:0] obs(input int k);
    case (k)
      0:       return {dv_1, do_1};
      1:       return {dv_4, do_4};
      default: return {dv_8, do_8};
    endcase
  endfunction

  task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got={v=%b d=%h} exp={v=%b d=%h}",
               tag, cyc, got[16], got[15:0], exp[16], exp[15:0]);
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++)
      check($sformatf("%s_L%0d", tag, lat[k]), obs(k), exp_t[k][cyc+1]);
  endtask

  // One clock: present the request, let the edge take it, update the model,
  // then compare what will be sampled at the following edge.
  task automatic step(input logic en, input logic w, input logic [15:0] a,
                      input logic [15:0] d, input string tag = "cyc");
    enable = en; wr = w; addr = a; data_in = d;
    @(posedge clk);
    cyc++;
    if (cyc + 9 >= MAXC) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      n_bad++;
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
    end
    if (rst_n && en) begin
      if (w) mem_m[a[15:1]] = d;
      else for (int k = 0; k < 3; k++) exp_t[k][cyc + lat[k]] = {1'b1, mem_m[a[15:1]]};
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  // Reset asserted mid-cycle; in-flight reads vanish. A write strobed while
  // reset is low must not reach storage.
  task automatic pulse_reset(input int n_low);
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      for (int j = cyc + 1; j < MAXC; j++) exp_t[k][j] = '0;
      check($sformatf("rst_async_L%0d", lat[k]), obs(k), 17'h0);
    end
    for (int i = 0; i < n_low; i++) step(1'b1, 1'b1, 16'h0040, 16'hDEAD, "in_rst");
    rst_n = 1'b1;
  endtask

  logic [15:0] pool [16] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006,
                             16'h0010, 16'h0020, 16'h0040, 16'h0100,
                             16'h1234, 16'h7FFE, 16'h8000, 16'hA5A4,
                             16'hC000, 16'hFFFA, 16'hFFFC, 16'hFFFE};

  initial begin
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < MAXC; j++) exp_t[k][j] = '0;

    // Reset state, with a request presented while reset is held.
    #1;
    check_all("reset");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "reset");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, "reset");
    rst_n = 1'b1;

    // Write then read-after-write; explicit timing check on the LATENCY=4 copy.
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF, "raw");
    step(1'b1, 1'b0, 16'h0010, 16'h0000, "raw");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, "raw");
    step(1'b0, 1'b0, 16'h0000, 16'h0000, "raw");
    check("beef_L4_early", {dv_4, do_4}, 17'h0);
    step(1'b0, 1'b0, 16'h0000, 16'h0000, "raw");
    check("beef_L4", {dv_4, do_4}, {1'b1, 16'hBEEF});
    idle(8);

    // Preload four words, then four back-to-back reads.
    step(1'b1, 1'b1, 16'h0000, 16'h1111, "pre");
    step(1'b1, 1'b1, 16'h0002, 16'h2222, "pre");
    step(1'b1, 1'b1, 16'h0004, 16'h3333, "pre");
    step(1'b1, 1'b1, 16'h0006, 16'h4444, "pre");
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "b2b");
    step(1'b1, 1'b0, 16'h0002, 16'h0000, "b2b");
    step(1'b1, 1'b0, 16'h0004, 16'h0000, "b2b");
    step(1'b1, 1'b0, 16'h0006, 16'h0000, "b2b");
    idle(9);

    // Snapshot: read, overwrite, read again.
    step(1'b1, 1'b1, 16'h0020, 16'h00AA, "snap");
    step(1'b1, 1'b0, 16'h0020, 16'h0000, "snap");
    step(1'b1, 1'b1, 16'h0020, 16'h0055, "snap");
    step(1'b1, 1'b0, 16'h0020, 16'h0000, "snap");
    idle(9);

    // Address wrap and enable=0 writes.
    step(1'b1, 1'b1, 16'hFFFF, 16'h1234, "wrap");
    step(1'b1, 1'b0, 16'hFFFE, 16'h0000, "wrap");
    step(1'b1, 1'b1, 16'h0040, 16'h7777, "en0");
    step(1'b0, 1'b1, 16'h0040, 16'h9999, "en0");
    step(1'b1, 1'b0, 16'h0040, 16'h0000, "en0");
    idle(9);

    // Three reads, reset two cycles later, then silence; storage survives.
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "rstmid");
    step(1'b1, 1'b0, 16'h0002, 16'h0000, "rstmid");
    step(1'b1, 1'b0, 16'h0004, 16'h0000, "rstmid");
    idle(2);
    pulse_reset(1);
    idle(10);
    step(1'b1, 1'b0, 16'h0000, 16'h0000, "retain");
    step(1'b1, 1'b0, 16'h0040, 16'h0000, "retain");
    idle(9);

    // Randomized traffic over a pool of pre-written words.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, pool[i], 16'($urandom), "rfill");
    for (int i = 0; i < 1500; i++) begin
      int unsigned op;
      logic [15:0] a;
      op = $urandom_range(0, 99);
      a  = pool[$urandom_range(0, 15)] | 16'($urandom_range(0, 1));
      if (op < 45)      step(1'b1, 1'b0, a, 16'($urandom), "rand");
      else if (op < 75) step(1'b1, 1'b1, a, 16'($urandom), "rand");
      else if (op < 98) step(1'b0, 1'($urandom_range(0, 1)), a, 16'($urandom), "rand");
      else              pulse_reset(int'($urandom_range(1, 2)));
    end
    idle(10);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
